// File: rtl/sdram_burst_sched_if.sv
// sdram_burst_sched_if: command handshake between the burst scheduler (master) and the SDRAM command engine (slave).
interface sdram_burst_sched_if #(parameter int ADDR_W = 22);
   logic [1:0]        cmd_req;
   logic [ADDR_W-1:0] cmd_addr;
   logic [8:0]        cmd_len;
   logic              cmd_ack;
   logic              cmd_done;
   modport master(output cmd_req, cmd_addr, cmd_len, input cmd_ack, cmd_done);
   modport slave(input cmd_req, cmd_addr, cmd_len, output cmd_ack, cmd_done);
endinterface

// File: rtl/sdram_burst_sched.sv
// sdram_burst_sched: picks refresh/write/read bursts for the SDRAM engine and tracks frame pointers.
// Defining WR_FLUSH_EN adds wr_flush, which lets residual camera words be written as a short burst.
module sdram_burst_sched #(
   parameter int BURST_LEN  = 256,
   parameter int ADDR_W     = 22,
   parameter int USED_W     = 10,
   parameter int RD_LOW_TH  = 256,
   parameter int REF_PERIOD = 780
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init_done,
   input  logic [USED_W-1:0] wr_usedw,
   input  logic [USED_W-1:0] rd_usedw,
   input  logic [ADDR_W-1:0] wr_base,
   input  logic [ADDR_W-1:0] wr_max,
   input  logic              wr_load,
   input  logic [ADDR_W-1:0] rd_base,
   input  logic [ADDR_W-1:0] rd_max,
   input  logic              rd_load,
`ifdef WR_FLUSH_EN
   input  logic              wr_flush,
`endif
   sdram_burst_sched_if.master cmd,
   output logic              frame_write_done,
   output logic              frame_read_done,
   output logic              busy
);
   localparam int RW = $clog2(REF_PERIOD + 1);
   localparam logic [ADDR_W-1:0] BL  = ADDR_W'(BURST_LEN);
   localparam logic [USED_W:0]   BLU = (USED_W + 1)'(BURST_LEN);
   localparam logic [USED_W:0]   RDT = (USED_W + 1)'(RD_LOW_TH);
   localparam logic [RW-1:0]     RP  = RW'(REF_PERIOD);
   localparam logic [1:0] NONE = 2'b00, REF = 2'b01, WR = 2'b10, RD = 2'b11;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
   state_t state;
   logic [1:0] op, grant;
   logic [RW-1:0] ref_cnt;
   logic [ADDR_W-1:0] wr_ptr, rd_ptr, wp, rp, wr_rem, rd_rem, wr_lim, wr_nxt, rd_nxt;
   logic [8:0] wr_len, rd_len;
   logic last_rd, wr_lp, rd_lp, wr_full, wr_want, rd_want, ref_pend;
`ifdef WR_FLUSH_EN
   logic flush_pend;
`endif

   assign ref_pend = ref_cnt == RP;

   // an idle load takes effect in the same cycle it could be granted, so the burst starts at base
   always_comb begin
      wp = wr_load ? wr_base : wr_ptr;
      rp = rd_load ? rd_base : rd_ptr;
      wr_full = {1'b0, wr_usedw} >= BLU;
      wr_lim = wr_full ? BL : ADDR_W'(wr_usedw);
      wr_rem = wr_max - wp;
      rd_rem = rd_max - rp;
      wr_len = wr_rem < wr_lim ? wr_rem[8:0] : wr_lim[8:0];
      rd_len = rd_rem < BL ? rd_rem[8:0] : BL[8:0];
`ifdef WR_FLUSH_EN
      wr_want = wr_full || (flush_pend && wr_usedw != '0);
`else
      wr_want = wr_full;
`endif
      rd_want = {1'b0, rd_usedw} < RDT;
      grant = !init_done ? NONE : ref_pend ? REF : (wr_want && (!rd_want || last_rd)) ? WR : rd_want ? RD : NONE;
      wr_nxt = wr_ptr + ADDR_W'(cmd.cmd_len);
      rd_nxt = rd_ptr + ADDR_W'(cmd.cmd_len);
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         op <= NONE;
         last_rd <= 1'b1;
         ref_cnt <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         wr_lp <= 1'b0;
         rd_lp <= 1'b0;
         cmd.cmd_req <= NONE;
         cmd.cmd_addr <= '0;
         cmd.cmd_len <= '0;
         busy <= 1'b0;
         frame_write_done <= 1'b0;
         frame_read_done <= 1'b0;
`ifdef WR_FLUSH_EN
         flush_pend <= 1'b0;
`endif
      end else begin
         frame_write_done <= 1'b0;
         frame_read_done <= 1'b0;
         ref_cnt <= (!init_done || (state == IDLE && grant == REF)) ? '0 : ref_pend ? ref_cnt : ref_cnt + 1'b1;
`ifdef WR_FLUSH_EN
         flush_pend <= wr_flush ? 1'b1 : (wr_usedw == '0 || wr_load) ? 1'b0 : flush_pend;
`endif
         if (state == IDLE) begin
            wr_ptr <= wp;
            rd_ptr <= rp;
            if (grant != NONE) begin
               state <= REQ;
               op <= grant;
               busy <= 1'b1;
               cmd.cmd_req <= grant;
               cmd.cmd_addr <= grant == WR ? wp : grant == RD ? rp : '0;
               cmd.cmd_len <= grant == WR ? wr_len : grant == RD ? rd_len : '0;
               if (grant[1]) last_rd <= grant[0];
            end
         end else begin
            // a load aimed at the burst in flight is deferred so its increment cannot clobber it
            if (wr_load) begin
               if (op == WR) wr_lp <= 1'b1;
               else wr_ptr <= wr_base;
            end
            if (rd_load) begin
               if (op == RD) rd_lp <= 1'b1;
               else rd_ptr <= rd_base;
            end
            if (state == REQ && cmd.cmd_ack) begin
               state <= WAIT;
               cmd.cmd_req <= NONE;
            end
            if (state == WAIT && cmd.cmd_done) begin
               state <= IDLE;
               busy <= 1'b0;
               if (op == WR) begin
                  wr_lp <= 1'b0;
                  wr_ptr <= (wr_lp || wr_load || wr_nxt == wr_max) ? wr_base : wr_nxt;
                  frame_write_done <= !(wr_lp || wr_load) && wr_nxt == wr_max;
               end
               if (op == RD) begin
                  rd_lp <= 1'b0;
                  rd_ptr <= (rd_lp || rd_load || rd_nxt == rd_max) ? rd_base : rd_nxt;
                  frame_read_done <= !(rd_lp || rd_load) && rd_nxt == rd_max;
               end
            end
         end
      end
endmodule
